// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor: computes a - b (mod 2^WIDTH) one bit per clock,
// LSB first, through a single 1-bit fullsubtractor cell. The cell's borrow
// out is registered and fed back as the next bit's borrow in.
//
// Handshake: start is sampled only in IDLE. busy is high for WIDTH cycles
// while bits are processed, then done pulses for one cycle. diff and bout
// hold their values until the next accepted start.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   When defined, adds the ovf output (signed overflow of a - b) and the
//   operand MSB capture registers it needs.
//
// Parameters:
//   WIDTH  operand / result width in bits (>= 2)
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   operation request, sampled only in IDLE
//   a      in   minuend, captured on accepted start
//   b      in   subtrahend, captured on accepted start
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when the result is valid
//   diff   out  a - b mod 2^WIDTH
//   bout   out  final borrow (1 when a < b unsigned)
//   ovf    out  signed overflow (only with SERIAL_SUB_OVF_EN)
// ---------------------------------------------------------------------------

// 1-bit full subtractor cell: d = a - b - bin, with borrow out.
module fullsubtractor (
    output logic d,
    output logic bout,
    input  logic a,
    input  logic b,
    input  logic bin
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             cell_d;
    logic             cell_bout;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    fullsubtractor u_cell (cell_d, cell_bout, sa[0], sb[0], br);

    // Control FSM and datapath. The result bit enters diff at the MSB and
    // shifts right, so after WIDTH edges the LSB computed first sits at
    // diff[0]. busy/done are registered alongside the state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        diff  <= '0;
                        bout  <= 1'b0;
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= 1'b0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end
                end

                SHIFT: begin
                    diff <= {cell_d, diff[WIDTH-1:1]};
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    br   <= cell_bout;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        bout  <= cell_bout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        // cell_d is the result MSB being shifted in this edge.
                        ovf   <= (a_msb != b_msb) && (cell_d != a_msb);
`endif
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor (WIDTH = 8). Expected results
// come from plain integer arithmetic on the operands. Honours the
// SERIAL_SUB_OVF_EN macro: ovf is connected and checked only when defined.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf_val;

    int total;
    int bad;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf_val)
`endif
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf_val = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the operands.
    function automatic logic [W-1:0] model_diff(input logic [W-1:0] av, input logic [W-1:0] bv);
        int r;
        r = (int'(av) - int'(bv)) % (1 << W);
        if (r < 0) r += (1 << W);
        return W'(r);
    endfunction

    function automatic logic model_bout(input logic [W-1:0] av, input logic [W-1:0] bv);
        return int'(av) < int'(bv);
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] av, input logic [W-1:0] bv);
        int sa;
        int sb;
        int sd;
        sa = av[W-1] ? int'(av) - (1 << W) : int'(av);
        sb = bv[W-1] ? int'(bv) - (1 << W) : int'(bv);
        sd = sa - sb;
        return (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
    endfunction

    // Launch one operation and observe a fixed window of W+4 cycles.
    // Optionally pulses start with 0xFF/0x00 at window index pulse_idx.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int pulse_idx,
                          output int nbusy, output int ndone, output int done_at,
                          output logic [W-1:0] rdiff, output logic rbout, output logic rovf,
                          output logic [W-1:0] hold_diff);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        nbusy = 0; ndone = 0; done_at = -1;
        rdiff = 'x; rbout = 1'bx; rovf = 1'bx;
        for (int i = 0; i < W + 4; i++) begin
            if (i > 0) @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = i;
                rdiff = diff; rbout = bout; rovf = ovf_val;
            end
            if (i == pulse_idx) begin
                start = 1'b1; a = 8'hFF; b = 8'h00;
            end else begin
                start = 1'b0;
            end
        end
        hold_diff = diff;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        total++; if (diff !== '0)   begin bad++; $display("[TB] FAIL reset_diff got=%h want=00", diff); end
        total++; if (bout !== 1'b0) begin bad++; $display("[TB] FAIL reset_bout got=%b want=0", bout); end
        total++; if (ovf_val !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%b want=0", ovf_val); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] av [4];
        logic [W-1:0] bv [4];
        int nb, nd, da;
        logic [W-1:0] rd, hd;
        logic rb, ro;
        av[0] = 8'h5A; bv[0] = 8'h23;
        av[1] = 8'h23; bv[1] = 8'h5A;
        av[2] = 8'h00; bv[2] = 8'h01;
        av[3] = 8'h80; bv[3] = 8'h01;
        for (int k = 0; k < 4; k++) begin
            run_op(av[k], bv[k], -1, nb, nd, da, rd, rb, ro, hd);
            total++; if (nb !== W) begin bad++; $display("[TB] FAIL dir%0d_busy_cycles got=%0d want=%0d", k, nb, W); end
            total++; if (nd !== 1 || da !== W) begin bad++; $display("[TB] FAIL dir%0d_done got=%0d@%0d want=1@%0d", k, nd, da, W); end
            total++; if (rd !== model_diff(av[k], bv[k])) begin bad++; $display("[TB] FAIL dir%0d_diff got=%h want=%h", k, rd, model_diff(av[k], bv[k])); end
            total++; if (rb !== model_bout(av[k], bv[k])) begin bad++; $display("[TB] FAIL dir%0d_bout got=%b want=%b", k, rb, model_bout(av[k], bv[k])); end
            total++; if (hd !== model_diff(av[k], bv[k])) begin bad++; $display("[TB] FAIL dir%0d_hold got=%h want=%h", k, hd, model_diff(av[k], bv[k])); end
`ifdef SERIAL_SUB_OVF_EN
            total++; if (ro !== model_ovf(av[k], bv[k])) begin bad++; $display("[TB] FAIL dir%0d_ovf got=%b want=%b", k, ro, model_ovf(av[k], bv[k])); end
`endif
        end
    endtask

    task automatic test_random();
        int nb, nd, da;
        logic [W-1:0] rd, hd, av, bv;
        logic rb, ro;
        for (int k = 0; k < 16; k++) begin
            av = W'($urandom);
            bv = W'($urandom);
            run_op(av, bv, -1, nb, nd, da, rd, rb, ro, hd);
            total++; if (nd !== 1 || da !== W || nb !== W) begin bad++; $display("[TB] FAIL rnd%0d_timing busy=%0d done=%0d@%0d", k, nb, nd, da); end
            total++; if (rd !== model_diff(av, bv)) begin bad++; $display("[TB] FAIL rnd%0d_diff a=%h b=%h got=%h want=%h", k, av, bv, rd, model_diff(av, bv)); end
            total++; if (rb !== model_bout(av, bv)) begin bad++; $display("[TB] FAIL rnd%0d_bout got=%b want=%b", k, rb, model_bout(av, bv)); end
`ifdef SERIAL_SUB_OVF_EN
            total++; if (ro !== model_ovf(av, bv)) begin bad++; $display("[TB] FAIL rnd%0d_ovf got=%b want=%b", k, ro, model_ovf(av, bv)); end
`endif
        end
    endtask

    task automatic test_start_ignored();
        int nb, nd, da;
        logic [W-1:0] rd, hd;
        logic rb, ro;
        run_op(8'h5A, 8'h23, 2, nb, nd, da, rd, rb, ro, hd);
        total++; if (nd !== 1) begin bad++; $display("[TB] FAIL ign_done_count got=%0d want=1", nd); end
        total++; if (rd !== 8'h37) begin bad++; $display("[TB] FAIL ign_diff got=%h want=37", rd); end
        total++; if (hd !== 8'h37) begin bad++; $display("[TB] FAIL ign_hold got=%h want=37", hd); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL ign_relaunch busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        int nb, nd, da, ndone;
        logic [W-1:0] rd, hd;
        logic rb, ro;
        @(negedge clk);
        a = 8'h23; b = 8'h5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_ctl busy=%b done=%b want=0/0", busy, done); end
        total++; if (diff !== '0 || bout !== 1'b0 || ovf_val !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_data diff=%h bout=%b ovf=%b want=0", diff, bout, ovf_val); end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("[TB] FAIL rstmid_no_done got=%0d want=0", ndone); end
        run_op(8'h10, 8'h10, -1, nb, nd, da, rd, rb, ro, hd);
        total++; if (nd !== 1 || rd !== 8'h00 || rb !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_after done=%0d diff=%h bout=%b want=1/00/0", nd, rd, rb); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2;
        int dcount;
        int d_at [2];
        logic [W-1:0] dres [2];
        logic bres [2];
        a1 = W'($urandom); b1 = W'($urandom);
        a2 = W'($urandom); b2 = W'($urandom);
        dcount = 0; d_at[0] = -1; d_at[1] = -1;
        dres[0] = 'x; dres[1] = 'x; bres[0] = 1'bx; bres[1] = 1'bx;
        @(negedge clk);
        a = a1; b = b1; start = 1'b1;
        @(negedge clk);
        a = a2; b = b2;
        for (int i = 0; i < 2 * (W + 2) + 2; i++) begin
            if (i > 0) @(negedge clk);
            if (done) begin
                if (dcount < 2) begin d_at[dcount] = i; dres[dcount] = diff; bres[dcount] = bout; end
                dcount++;
            end
            if (i == W + 4) start = 1'b0;
        end
        total++; if (dcount !== 2) begin bad++; $display("[TB] FAIL b2b_done_count got=%0d want=2", dcount); end
        total++; if (d_at[0] !== W || d_at[1] !== 2 * W + 2) begin bad++; $display("[TB] FAIL b2b_done_time got=%0d,%0d want=%0d,%0d", d_at[0], d_at[1], W, 2 * W + 2); end
        total++; if (dres[0] !== model_diff(a1, b1) || bres[0] !== model_bout(a1, b1)) begin bad++; $display("[TB] FAIL b2b_first got=%h/%b want=%h/%b", dres[0], bres[0], model_diff(a1, b1), model_bout(a1, b1)); end
        total++; if (dres[1] !== model_diff(a2, b2) || bres[1] !== model_bout(a2, b2)) begin bad++; $display("[TB] FAIL b2b_second got=%h/%b want=%h/%b", dres[1], bres[1], model_diff(a2, b2), model_bout(a2, b2)); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
